// File: rtl/mem_access_stage.sv
// MEM pipeline stage: one handshaked RAM access per load/store, store lane steering,
// watchdog abort and registered WB outputs. Optional halfword support: MEM_HALFWORD_EN.
module mem_access_stage #(
    parameter int MAX_WAIT   = 16,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  flush,
    input  logic                  mem_read_in,
    input  logic                  mem_write_in,
    input  logic                  mem_sign_ext_in,
    input  logic [3:0]            mem_sel_in,
    input  logic [31:0]           result_in,
    input  logic [31:0]           store_data_in,
    input  logic                  reg_write_en_in,
    input  logic [4:0]            reg_write_addr_in,
    input  logic                  cp_write_en_in,
    input  logic [4:0]            cp_write_addr_in,
    input  logic [31:0]           pc_in,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [31:0]           ram_wdata,
    input  logic                  ram_ready,
    input  logic [31:0]           ram_rdata,
    output logic                  stall_req,
    output logic                  wb_mem_read,
    output logic                  wb_mem_write,
    output logic                  wb_mem_sign_ext,
    output logic [3:0]            wb_mem_sel,
    output logic [31:0]           wb_result,
    output logic                  wb_reg_write_en,
    output logic [4:0]            wb_reg_write_addr,
    output logic                  wb_cp_write_en,
    output logic [4:0]            wb_cp_write_addr,
    output logic [31:0]           wb_pc,
    output logic [31:0]           wb_ram_read_data,
    output logic                  exc_addr_err,
    output logic                  exc_bus_err
);

    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_REQ  = 1'b1
    } state_t;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic        mem_sign_ext;
        logic [3:0]  mem_sel;
        logic [31:0] result;
        logic        reg_write_en;
        logic [4:0]  reg_write_addr;
        logic        cp_write_en;
        logic [4:0]  cp_write_addr;
        logic [31:0] pc;
    } wb_pkt_t;

    state_t                  state_r;
    state_t                  state_nxt_s;
    logic [CNT_W-1:0]        cnt_r;
    logic                    flushed_r;
    wb_pkt_t                 hold_r;
    wb_pkt_t                 wb_r;
    logic [31:0]             rdata_r;
    logic                    exc_addr_r;
    logic                    exc_bus_r;
    logic                    ram_en_r;
    logic [3:0]              ram_we_r;
    logic [ADDR_WIDTH-1:0]   ram_addr_r;
    logic [31:0]             ram_wdata_r;

    logic                    mem_op_s;
    logic                    legal_s;
    logic [3:0]              we_s;
    logic [31:0]             wdata_s;
    logic                    stall_s;
    logic                    start_s;
    logic                    done_s;
    logic                    abort_s;
    logic                    bad_s;
    logic                    pass_s;
    logic                    kill_s;
    wb_pkt_t                 in_pkt_s;
    wb_pkt_t                 err_pkt_s;

    assign mem_op_s = in_valid & ~flush & (mem_read_in | mem_write_in);
    assign kill_s   = flushed_r | flush;

    // Pack the incoming instruction and its address-error bubble
    always_comb begin
        in_pkt_s                = '0;
        in_pkt_s.mem_read       = mem_read_in;
        in_pkt_s.mem_write      = mem_write_in;
        in_pkt_s.mem_sign_ext   = mem_sign_ext_in;
        in_pkt_s.mem_sel        = mem_sel_in;
        in_pkt_s.result         = result_in;
        in_pkt_s.reg_write_en   = reg_write_en_in;
        in_pkt_s.reg_write_addr = reg_write_addr_in;
        in_pkt_s.cp_write_en    = cp_write_en_in;
        in_pkt_s.cp_write_addr  = cp_write_addr_in;
        in_pkt_s.pc             = pc_in;
        err_pkt_s               = '0;
        err_pkt_s.result        = result_in;
    end

    // Access legality and store lane steering from size and low address bits
    always_comb begin
        legal_s = 1'b0;
        we_s    = 4'b0000;
        wdata_s = store_data_in;
        case (mem_sel_in)
            4'b0001: begin
                legal_s = 1'b1;
                we_s    = 4'b0001 << result_in[1:0];
                wdata_s = {4{store_data_in[7:0]}};
            end
            4'b1111: begin
                legal_s = (result_in[1:0] == 2'b00);
                we_s    = 4'b1111;
                wdata_s = store_data_in;
            end
`ifdef MEM_HALFWORD_EN
            4'b0011: begin
                legal_s = ~result_in[0];
                we_s    = 4'b0011 << result_in[1:0];
                wdata_s = {2{store_data_in[15:0]}};
            end
`endif
            default: begin
                legal_s = 1'b0;
                we_s    = 4'b0000;
                wdata_s = store_data_in;
            end
        endcase
    end

    // Next-state and handshake control
    always_comb begin
        state_nxt_s = state_r;
        stall_s     = 1'b0;
        start_s     = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        bad_s       = 1'b0;
        pass_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op_s) begin
                    if (legal_s) begin
                        stall_s     = 1'b1;
                        start_s     = 1'b1;
                        state_nxt_s = ST_REQ;
                    end else begin
                        bad_s = 1'b1;
                    end
                end else begin
                    pass_s = 1'b1;
                end
            end
            ST_REQ: begin
                if (ram_ready) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (cnt_r == CNT_LAST) begin
                    stall_s     = 1'b1;
                    abort_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    stall_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Stall is suppressed while reset is held so upstream never freezes on stale input
    assign stall_req = stall_s & rst_n;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // RAM request registers, wait counter and captured instruction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_en_r    <= 1'b0;
            ram_we_r    <= 4'b0000;
            ram_addr_r  <= '0;
            ram_wdata_r <= 32'd0;
            cnt_r       <= '0;
            flushed_r   <= 1'b0;
            hold_r      <= '0;
        end else if (start_s) begin
            ram_en_r    <= 1'b1;
            ram_we_r    <= mem_write_in ? we_s : 4'b0000;
            ram_addr_r  <= {result_in[ADDR_WIDTH-1:2], 2'b00};
            ram_wdata_r <= wdata_s;
            cnt_r       <= '0;
            flushed_r   <= 1'b0;
            hold_r      <= in_pkt_s;
        end else if (done_s || abort_s) begin
            ram_en_r <= 1'b0;
            ram_we_r <= 4'b0000;
        end else if (state_r == ST_REQ) begin
            cnt_r     <= cnt_r + CNT_W'(1);
            flushed_r <= flushed_r | flush;
        end
    end

    // WB registers: pass-through, address-error bubble, completed access, else bubble
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_r       <= '0;
            rdata_r    <= 32'd0;
            exc_addr_r <= 1'b0;
            exc_bus_r  <= 1'b0;
        end else begin
            exc_addr_r <= bad_s;
            exc_bus_r  <= abort_s;
            if (pass_s) begin
                wb_r    <= (in_valid && !flush) ? in_pkt_s : '0;
                rdata_r <= 32'd0;
            end else if (bad_s) begin
                wb_r    <= err_pkt_s;
                rdata_r <= 32'd0;
            end else if (done_s && !kill_s) begin
                wb_r    <= hold_r;
                rdata_r <= ram_rdata;
            end else begin
                wb_r    <= '0;
                rdata_r <= 32'd0;
            end
        end
    end

    assign ram_en            = ram_en_r;
    assign ram_we            = ram_we_r;
    assign ram_addr          = ram_addr_r;
    assign ram_wdata         = ram_wdata_r;
    assign wb_mem_read       = wb_r.mem_read;
    assign wb_mem_write      = wb_r.mem_write;
    assign wb_mem_sign_ext   = wb_r.mem_sign_ext;
    assign wb_mem_sel        = wb_r.mem_sel;
    assign wb_result         = wb_r.result;
    assign wb_reg_write_en   = wb_r.reg_write_en;
    assign wb_reg_write_addr = wb_r.reg_write_addr;
    assign wb_cp_write_en    = wb_r.cp_write_en;
    assign wb_cp_write_addr  = wb_r.cp_write_addr;
    assign wb_pc             = wb_r.pc;
    assign wb_ram_read_data  = rdata_r;
    assign exc_addr_err      = exc_addr_r;
    assign exc_bus_err       = exc_bus_r;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// instructions checked against a transaction-level model of the stage.
module tb_mem_access_stage;

    localparam int MAX_WAIT = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0;
    logic        mem_read_in = 1'b0, mem_write_in = 1'b0, mem_sign_ext_in = 1'b0;
    logic [3:0]  mem_sel_in = 4'd0;
    logic [31:0] result_in = 32'd0, store_data_in = 32'd0, pc_in = 32'd0;
    logic        reg_write_en_in = 1'b0, cp_write_en_in = 1'b0;
    logic [4:0]  reg_write_addr_in = 5'd0, cp_write_addr_in = 5'd0;
    logic        ram_en, stall_req, ram_ready = 1'b0;
    logic [3:0]  ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata = 32'd0;
    logic        wb_mem_read, wb_mem_write, wb_mem_sign_ext;
    logic [3:0]  wb_mem_sel;
    logic [31:0] wb_result, wb_pc, wb_ram_read_data;
    logic        wb_reg_write_en, wb_cp_write_en;
    logic [4:0]  wb_reg_write_addr, wb_cp_write_addr;
    logic        exc_addr_err, exc_bus_err;

    int total = 0;
    int bad = 0;

    // Current instruction fields
    logic        rd, wr, sx, rwe, cwe;
    logic [3:0]  sel;
    logic [31:0] res, sd, pc;
    logic [4:0]  raddr, caddr;

    mem_access_stage #(.MAX_WAIT(MAX_WAIT), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .flush(flush),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .mem_sign_ext_in(mem_sign_ext_in), .mem_sel_in(mem_sel_in),
        .result_in(result_in), .store_data_in(store_data_in),
        .reg_write_en_in(reg_write_en_in), .reg_write_addr_in(reg_write_addr_in),
        .cp_write_en_in(cp_write_en_in), .cp_write_addr_in(cp_write_addr_in),
        .pc_in(pc_in), .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_ready(ram_ready), .ram_rdata(ram_rdata),
        .stall_req(stall_req), .wb_mem_read(wb_mem_read), .wb_mem_write(wb_mem_write),
        .wb_mem_sign_ext(wb_mem_sign_ext), .wb_mem_sel(wb_mem_sel),
        .wb_result(wb_result), .wb_reg_write_en(wb_reg_write_en),
        .wb_reg_write_addr(wb_reg_write_addr), .wb_cp_write_en(wb_cp_write_en),
        .wb_cp_write_addr(wb_cp_write_addr), .wb_pc(wb_pc),
        .wb_ram_read_data(wb_ram_read_data), .exc_addr_err(exc_addr_err),
        .exc_bus_err(exc_bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference rules: which accesses are legal, which lanes, which data
    function automatic bit legal_f(input logic [3:0] s, input logic [31:0] a);
        if (s == 4'b0001) return 1'b1;
        if (s == 4'b1111) return (a % 32'd4) == 32'd0;
`ifdef MEM_HALFWORD_EN
        if (s == 4'b0011) return (a % 32'd2) == 32'd0;
`endif
        return 1'b0;
    endfunction

    function automatic logic [3:0] we_f(input logic [3:0] s, input logic [31:0] a);
        if (s == 4'b0001) return 4'(32'd1 << (a % 32'd4));
        if (s == 4'b0011) return 4'(32'd3 << (a % 32'd4));
        return 4'b1111;
    endfunction

    function automatic logic [31:0] wdata_f(input logic [3:0] s, input logic [31:0] d);
        if (s == 4'b0001) return {24'd0, d[7:0]} * 32'h0101_0101;
        if (s == 4'b0011) return {16'd0, d[15:0]} * 32'h0001_0001;
        return d;
    endfunction

    task automatic rand_fields();
        res = $urandom; sd = $urandom; pc = $urandom;
        sx = 1'($urandom % 2); rwe = 1'($urandom % 2); cwe = 1'($urandom % 2);
        raddr = 5'($urandom); caddr = 5'($urandom); sel = 4'($urandom);
    endtask

    task automatic drive();
        in_valid = 1'b1; mem_read_in = rd; mem_write_in = wr; mem_sign_ext_in = sx;
        mem_sel_in = sel; result_in = res; store_data_in = sd; pc_in = pc;
        reg_write_en_in = rwe; reg_write_addr_in = raddr;
        cp_write_en_in = cwe; cp_write_addr_in = caddr;
    endtask

    task automatic idle();
        in_valid = 1'b0; flush = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    endtask

    task automatic check_wb(input bit kill, input logic [31:0] exp_rdata);
        chk("wb_result", wb_result, kill ? 32'd0 : res);
        chk("wb_ctl", {25'd0, wb_mem_read, wb_mem_write, wb_mem_sign_ext, wb_mem_sel},
            kill ? 32'd0 : {25'd0, rd, wr, sx, sel});
        chk("wb_reg", {26'd0, wb_reg_write_en, wb_reg_write_addr},
            kill ? 32'd0 : {26'd0, rwe, raddr});
        chk("wb_cp", {26'd0, wb_cp_write_en, wb_cp_write_addr},
            kill ? 32'd0 : {26'd0, cwe, caddr});
        chk("wb_pc", wb_pc, kill ? 32'd0 : pc);
        chk("wb_rdata", wb_ram_read_data, exp_rdata);
    endtask

    // Non-memory instruction (or a flushed one): one-cycle pass to WB, never stalls
    task automatic do_pass(input bit fl);
        @(negedge clk);
        drive(); flush = fl; ram_ready = 1'($urandom % 2);
        #1 chk("pass_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        idle(); ram_ready = 1'b0;
        #1 check_wb(fl, 32'd0);
        chk("pass_ram_en", {31'd0, ram_en}, 32'd0);
    endtask

    // Legal load/store; RAM answers after 'delay' waiting REQ cycles
    task automatic do_mem(input int delay, input bit fl);
        int stalls;
        logic [31:0] rdata;
        @(negedge clk);
        drive(); ram_ready = 1'b0;
        #1 chk("mem_stall_idle", {31'd0, stall_req}, 32'd1);
        chk("mem_en_idle", {31'd0, ram_en}, 32'd0);
        stalls = 1;
        @(negedge clk);
        flush = fl;
        #1 chk("mem_en", {31'd0, ram_en}, 32'd1);
        chk("mem_addr", ram_addr, res - (res % 32'd4));
        chk("mem_we", {28'd0, ram_we}, wr ? {28'd0, we_f(sel, res)} : 32'd0);
        if (wr) chk("mem_wdata", ram_wdata, wdata_f(sel, sd));
        for (int i = 0; i < delay; i++) begin
            if (stall_req === 1'b1) stalls++;
            @(negedge clk);
            #1;
        end
        rdata = $urandom;
        ram_ready = 1'b1; ram_rdata = rdata;
        #1 chk("mem_stall_ready", {31'd0, stall_req}, 32'd0);
        chk("mem_en_ready", {31'd0, ram_en}, 32'd1);
        chk("mem_stall_cycles", 32'(stalls), 32'(delay + 1));
        @(negedge clk);
        ram_ready = 1'b0; idle();
        #1 check_wb(fl, fl ? 32'd0 : rdata);
        chk("mem_en_after", {31'd0, ram_en}, 32'd0);
    endtask

    // Misaligned or unsupported size: no access, one exc_addr_err pulse
    task automatic do_bad();
        @(negedge clk);
        drive();
        #1 chk("bad_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        idle();
        #1 chk("bad_en", {31'd0, ram_en}, 32'd0);
        chk("bad_exc", {31'd0, exc_addr_err}, 32'd1);
        chk("bad_result", wb_result, res);
        chk("bad_wen", {30'd0, wb_reg_write_en, wb_cp_write_en}, 32'd0);
        @(negedge clk);
        #1 chk("bad_exc_pulse", {31'd0, exc_addr_err}, 32'd0);
    endtask

    task automatic do_timeout();
        int en_cycles = 0;
        @(negedge clk);
        drive(); ram_ready = 1'b0;
        #1 chk("to_stall", {31'd0, stall_req}, 32'd1);
        for (int i = 0; i < MAX_WAIT; i++) begin
            @(negedge clk);
            #1 if (ram_en === 1'b1) en_cycles++;
        end
        @(negedge clk);
        idle();
        #1 chk("to_en_cycles", 32'(en_cycles), 32'(MAX_WAIT));
        chk("to_en_drop", {31'd0, ram_en}, 32'd0);
        chk("to_exc", {31'd0, exc_bus_err}, 32'd1);
        chk("to_stall_rel", {31'd0, stall_req}, 32'd0);
        chk("to_wen", {31'd0, wb_reg_write_en}, 32'd0);
        @(negedge clk);
        #1 chk("to_exc_pulse", {31'd0, exc_bus_err}, 32'd0);
    endtask

    initial begin
        rd = 1'b0; wr = 1'b0; sx = 1'b0; rwe = 1'b0; cwe = 1'b0;
        sel = 4'd0; res = 32'd0; sd = 32'd0; pc = 32'd0; raddr = 5'd0; caddr = 5'd0;
        repeat (2) @(negedge clk);
        #1 chk("rst_en", {31'd0, ram_en}, 32'd0);
        chk("rst_stall", {31'd0, stall_req}, 32'd0);
        chk("rst_wb", wb_result | wb_pc | {31'd0, wb_reg_write_en}, 32'd0);
        chk("rst_exc", {30'd0, exc_addr_err, exc_bus_err}, 32'd0);
        rst_n = 1'b1;

        // ALU op straight through
        rand_fields(); rd = 1'b0; wr = 1'b0; res = 32'h1234; rwe = 1'b1; raddr = 5'd5;
        do_pass(1'b0);
        // sb to 0x103, RAM answers after three waiting cycles
        rand_fields(); rd = 1'b0; wr = 1'b1; sel = 4'b0001; res = 32'h103; sd = 32'hAB;
        do_mem(3, 1'b0);
        // lw 0x200 answered on the first REQ cycle
        rand_fields(); rd = 1'b1; wr = 1'b0; sel = 4'b1111; res = 32'h200;
        do_mem(0, 1'b0);
        // misaligned lw
        rand_fields(); rd = 1'b1; wr = 1'b0; sel = 4'b1111; res = 32'h202; rwe = 1'b1;
        do_bad();
        // halfword size
        rand_fields(); rd = 1'b0; wr = 1'b1; sel = 4'b0011; res = 32'h302;
        if (legal_f(sel, res)) do_mem(1, 1'b0); else do_bad();
        // store with no answer: watchdog abort
        rand_fields(); rd = 1'b0; wr = 1'b1; sel = 4'b1111; res = 32'h400; rwe = 1'b1;
        do_timeout();
        // flush while the access is in flight
        rand_fields(); rd = 1'b1; wr = 1'b0; sel = 4'b1111; res = 32'h500;
        do_mem(2, 1'b1);

        // reset mid-REQ
        rand_fields(); rd = 1'b1; wr = 1'b0; sel = 4'b1111; res = 32'h600;
        @(negedge clk);
        drive();
        @(negedge clk);
        #1 chk("rstq_en_before", {31'd0, ram_en}, 32'd1);
        rst_n = 1'b0;
        #1 chk("rstq_en", {31'd0, ram_en}, 32'd0);
        chk("rstq_stall", {31'd0, stall_req}, 32'd0);
        chk("rstq_wb", wb_result | wb_pc | wb_ram_read_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1; idle();
        do_mem(1, 1'b0);

        // randomized instruction stream
        for (int n = 0; n < 60; n++) begin
            rand_fields();
            case ($urandom % 4)
                0: begin
                    rd = 1'($urandom % 2); wr = 1'b0;
                    if (rd) do_pass(1'b1);
                    else do_pass(1'($urandom % 4 == 0));
                end
                default: begin
                    rd = 1'($urandom % 2); wr = ~rd;
                    case ($urandom % 4)
                        0: sel = 4'b0001;
                        1: sel = 4'b1111;
                        2: sel = 4'b0011;
                        default: sel = 4'($urandom);
                    endcase
                    if ($urandom % 2 == 0) res = res - (res % 32'd4);
                    if (legal_f(sel, res)) do_mem(int'($urandom % 6), 1'($urandom % 8 == 0));
                    else do_bad();
                end
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
